// File: rtl/except_ctrl.sv
// Exception and pipeline-control unit at the MEM/commit point of the MIPS pipeline.
// Prioritises exceptions, emits a one-cycle flush with a redirect PC, and builds the stall vector.
module except_ctrl #(
    parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
    parameter logic [31:0] VEC_BEV0 = 32'h80000180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [4:0]  mem_exc_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    output logic [31:0] except_type_o,
    output logic [31:0] except_pc_o,
    output logic        except_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  stall_o
);

    typedef enum logic {IDLE, FLUSH} state_e;

    localparam logic [31:0] CAUSE_WB_MASK = 32'h00C0_0300;

    state_e      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] status_fwd, cause_fwd, epc_fwd;
    logic        int_pending;

    // An mtc0 still in WB has not reached CP0 yet, so its value is bypassed here.
    always_comb begin
        status_fwd = cp0_status_i;
        cause_fwd  = cp0_cause_i;
        epc_fwd    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                5'd12:   status_fwd = wb_cp0_data_i;
                5'd13:   cause_fwd  = (cp0_cause_i & ~CAUSE_WB_MASK) | (wb_cp0_data_i & CAUSE_WB_MASK);
                5'd14:   epc_fwd    = wb_cp0_data_i;
                default: ;
            endcase
        end
    end

    assign int_pending = (|(cause_fwd[15:8] & status_fwd[15:8])) && status_fwd[0] && !status_fwd[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        case (state_q)
            IDLE: begin
                if (except_type_o != '0) begin
                    state_d  = FLUSH;
                    flush_d  = 1'b1;
                    if (except_type_o == 32'he)
                        new_pc_d = epc_fwd;
                    else
                        new_pc_d = status_fwd[22] ? VEC_BEV1 : VEC_BEV0;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MEM contents are stale during FLUSH, so no new exception may be raised there.
    always_comb begin
        except_type_o = '0;
        if (state_q == IDLE && mem_valid_i) begin
            if (int_pending)       except_type_o = 32'h1;
            else if (mem_exc_i[0]) except_type_o = 32'ha;
            else if (mem_exc_i[1]) except_type_o = 32'h8;
            else if (mem_exc_i[2]) except_type_o = 32'hd;
            else if (mem_exc_i[3]) except_type_o = 32'hc;
            else if (mem_exc_i[4]) except_type_o = 32'he;
        end

        stall_o = '0;
        if (!flush_q && except_type_o == '0) begin
            if (stallreq_ex_i)      stall_o = 6'b001111;
            else if (stallreq_id_i) stall_o = 6'b000111;
        end
    end

    assign except_pc_o           = mem_pc_i;
    assign except_in_delayslot_o = mem_in_delayslot_i;
    assign flush_o               = flush_q;
    assign new_pc_o              = new_pc_q;

endmodule
